divider: RTL and testbench

Sequential restoring divider that produces quotient and remainder of two WIDTH_IN-bit operands, one quotient bit per clock. It is the inverse companion of the team's combinational array multiplier. Within the arithmetic IP library it serves datapaths that can tolerate a multi-cycle latency in exchange for a small area footprint.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_step.sv | 31 +++
 rtl/divider.sv | 144 ++++++++++++++
 tb/tb_divider.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  // Controller states: waiting, iterating one quotient bit per clock, result cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand the divider supports.
  localparam int MAX_WIDTH = 32;

  // Quotient reported for a zero divisor; sliced down to the operand width.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Bits needed to count WIDTH_IN-1 down to 0 (never less than one bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// compare against the divisor and subtract when it fits.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // The compare is one bit wider than the operands so a shifted remainder
  // with its top bit set still compares correctly against the divisor.
  logic [WIDTH:0] partial;

  assign partial = {rem_i, msb_i};

  // Restore-or-subtract decision for this bit position.
  always_comb begin
    // NOTE: every output gets a default before the branch so no latch is inferred.
    rem_o   = partial[WIDTH-1:0];
    q_bit_o = 1'b0;
    if (partial >= {1'b0, divisor_i}) begin
      // The difference is below the divisor, so the low WIDTH bits are exact.
      rem_o   = partial[WIDTH-1:0] - divisor_i;
      q_bit_o = 1'b1;
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional build macro DIVIDER_SIGNED_EN selects two's-complement operands
// (magnitudes divided unsigned, signs restored when the result is loaded).
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH_IN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH_IN-1:0] a,
  input  logic [WIDTH_IN-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH_IN-1:0] q,
  output logic [WIDTH_IN-1:0] r,
  output logic                div_by_zero
);

  localparam int CNT_W = clog2(WIDTH_IN);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH_IN-1:0] dvd_q;      // dividend, shifts left and collects quotient bits
  logic [WIDTH_IN-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH_IN-1:0] rem_q;      // working remainder
  logic                busy_q;
  logic                done_q;
  logic [WIDTH_IN-1:0] q_q;
  logic [WIDTH_IN-1:0] r_q;
  logic                dbz_q;

  logic [WIDTH_IN-1:0] a_mag;
  logic [WIDTH_IN-1:0] b_mag;
  logic [WIDTH_IN-1:0] step_rem;
  logic                step_q_bit;
  logic [WIDTH_IN-1:0] quot_next;
  logic [WIDTH_IN-1:0] q_final;
  logic [WIDTH_IN-1:0] r_final;

  divider_step #(.WIDTH(WIDTH_IN)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH_IN-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  assign quot_next = {dvd_q[WIDTH_IN-2:0], step_q_bit};

`ifdef DIVIDER_SIGNED_EN
  logic neg_quot_q;   // operand signs differ
  logic neg_rem_q;    // dividend was negative

  assign a_mag   = a[WIDTH_IN-1] ? (~a + WIDTH_IN'(1)) : a;
  assign b_mag   = b[WIDTH_IN-1] ? (~b + WIDTH_IN'(1)) : b;
  // Most-negative / -1 yields a magnitude that wraps back to most-negative.
  assign q_final = neg_quot_q ? (~quot_next + WIDTH_IN'(1)) : quot_next;
  assign r_final = neg_rem_q  ? (~step_rem  + WIDTH_IN'(1)) : step_rem;
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign q_final = quot_next;
  assign r_final = step_rem;
`endif

  // Controller, datapath registers and registered outputs in one process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            dvd_q <= a_mag;
            dvs_q <= b_mag;
            rem_q <= '0;
            cnt_q <= CNT_W'(WIDTH_IN - 1);
`ifdef DIVIDER_SIGNED_EN
            neg_quot_q <= a[WIDTH_IN-1] ^ b[WIDTH_IN-1];
            neg_rem_q  <= a[WIDTH_IN-1];
`endif
            if (b == '0) begin
              // Zero divisor: no iteration, result is available next cycle.
              state_q <= DONE;
              done_q  <= 1'b1;
              q_q     <= DBZ_QUOTIENT[WIDTH_IN-1:0];
              r_q     <= a;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          rem_q <= step_rem;
          dvd_q <= quot_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            // Last bit: the step outputs already hold the final result.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_q     <= q_final;
            r_q     <= r_final;
            dbz_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed scenarios plus a randomized sweep
// against an arithmetic reference model (signed model when DIVIDER_SIGNED_EN).
module tb_divider;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divider #(.WIDTH_IN(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference result computed with plain integer division.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic edbz);
    if (mb == '0) begin
      eq   = '1;
      er   = ma;
      edbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      int sa, sb;
      sa   = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
      sb   = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
      eq   = W'(sa / sb);
      er   = W'(sa % sb);
`else
      eq   = ma / mb;
      er   = ma % mb;
`endif
      edbz = 1'b0;
    end
  endfunction

  // Called #1 after an edge; counts further edges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // One complete operation: accept edge, latency, results, single-cycle done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    logic [W-1:0] eq, er;
    logic         edbz;
    int           n;
    model(ta, tb_v, eq, er, edbz);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy_after_accept"}, busy, (tb_v != '0));
    wait_done(n);
    // Done appears W edges after the accept edge (W+1 cycles counting the start cycle).
    check({tag, " latency"}, n, (tb_v == '0) ? 0 : W);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    check({tag, " busy_in_done"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, " done_pulse_width"}, done, 1'b0);
  endtask

  initial begin
    int n;
    int done_seen;
    logic [W-1:0] ra, rb;

    // Reset state
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset q", q, 8'h00);
    check("reset r", r, 8'h00);
    check("reset dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 200 / 7
    run_op(8'hC8, 8'h07, "u200_7");
`ifndef DIVIDER_SIGNED_EN
    check("u200_7 q_const", q, 8'h1C);
    check("u200_7 r_const", r, 8'h04);
`endif

    // Divide by zero: done one cycle after accept, busy never high
    run_op(8'h05, 8'h00, "dbz5");
    check("dbz5 q_const", q, 8'hFF);
    check("dbz5 r_const", r, 8'h05);
    check("dbz5 dbz_const", div_by_zero, 1'b1);

    // Start during busy is ignored; a start in the done cycle is accepted
    @(negedge clk);
    a = 8'd255; b = 8'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'd10; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("busy_start latency_rest", n, W - 4);
    check("busy_start q", q, 8'd255);
    check("busy_start r", r, 8'd0);
    // Still inside the done cycle: request the next division now.
    a = 8'd10; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy", busy, 1'b1);
    check("b2b done_low", done, 1'b0);
    wait_done(n);
    check("b2b latency", n, W);
    check("b2b q", q, 8'd3);
    check("b2b r", r, 8'd1);

    // Reset mid-operation discards the result and clears the outputs
    @(negedge clk);
    a = 8'd100; b = 8'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst q", q, 8'h00);
    check("midrst r", r, 8'h00);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("midrst no_done_after_release", done_seen, 0);
    check("midrst busy_after_release", busy, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    run_op(8'h9C, 8'h07, "s-100_7");
    check("s-100_7 q_const", q, 8'hF2);
    check("s-100_7 r_const", r, 8'hFE);
    run_op(8'h80, 8'hFF, "s-128_-1");
    check("s-128_-1 q_const", q, 8'h80);
    check("s-128_-1 r_const", r, 8'h00);
    check("s-128_-1 dbz_const", div_by_zero, 1'b0);
`endif

    // Corner operands
    run_op(8'h00, 8'h01, "c0_1");
    run_op(8'hFF, 8'hFF, "c255_255");
    run_op(8'hFF, 8'h01, "c255_1");
    run_op(8'h01, 8'hFF, "c1_255");
    run_op(8'h00, 8'h00, "c0_0");
    run_op(8'h80, 8'hFF, "c128_255");
    run_op(8'h7F, 8'h80, "c127_128");

    // Randomized sweep with occasional zero and small divisors
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, $sformatf("rand%0d_%0h_%0h", i, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
